nand_logic_sequencer: RTL and testbench

Multi-cycle logic unit that builds NAND, AND, OR, NOR, XOR, XNOR and NOT from a single WIDTH-bit NAND stage. The stage is applied once per clock, and intermediate results are held in registers between cycles. It sits beside the ALU as the gate-level-faithful logic path, accepting one operation at a time through a start/busy/done handshake. Internally it instantiates one WIDTH-bit NAND stage plus a small FSM.

---
 rtl/nand_logic_sequencer_if.sv | 33 +++
 rtl/nand_logic_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_nand_logic_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nand_logic_sequencer_if.sv
// nand_logic_sequencer_if
//   Request/response bundle for the NAND logic sequencer.
//   master : drives start/op/a/b, observes busy/done/result/err
//   slave  : the sequencer side
//   start  : request, sampled only while busy=0
//   op     : opcode (000 NAND .. 110 NOT, 111 illegal)
//   a, b   : operands, latched with start
//   busy   : operation in flight
//   done   : one-cycle completion pulse
//   result : last completed result
//   err    : completed op was illegal (valid with done)
interface nand_logic_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, err
  );
endinterface

// File: rtl/nand_logic_sequencer.sv
// nand_logic_sequencer
//   Multi-cycle logic unit that builds NAND/AND/OR/NOR/XOR/XNOR/NOT out of a
//   single WIDTH-bit NAND stage applied once per clock.
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset
//   bus   : request/response bundle (slave side), see nand_logic_sequencer_if

module nand_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_z
);
  assign o_z = ~(i_x & i_y);
endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; busy=0
// RUN   | one NAND pass per cycle, r_p = passes completed so far
module nand_logic_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  nand_logic_sequencer_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [2:0]       r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_t2;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_z;
  logic             w_wr_t1;
  logic             w_wr_t2;
  logic             w_last;
  logic             w_illegal;

  nand_stage #(.WIDTH(WIDTH)) u_nand (
    .i_x (w_x),
    .i_y (w_y),
    .o_z (w_z)
  );

  assign w_illegal = (r_op == 3'b111);

  // Operand routing per (opcode, pass). Non-final passes write t1 or t2;
  // the final pass result goes straight to r_result.
  always_comb begin
    w_x     = r_a;
    w_y     = r_b;
    w_wr_t1 = 1'b0;
    w_wr_t2 = 1'b0;
    w_last  = 1'b0;
    case (r_op)
      OP_NAND: w_last = 1'b1;
      OP_NOT: begin
        w_y    = r_a;
        w_last = 1'b1;
      end
      OP_AND: begin
        if (r_p == 3'd0) begin
          w_wr_t1 = 1'b1;
        end else begin
          w_x    = r_t1;
          w_y    = r_t1;
          w_last = 1'b1;
        end
      end
      OP_OR, OP_NOR: begin
        case (r_p)
          3'd0: begin
            w_y     = r_a;
            w_wr_t1 = 1'b1;
          end
          3'd1: begin
            w_x     = r_b;
            w_wr_t2 = 1'b1;
          end
          3'd2: begin
            w_x = r_t1;
            w_y = r_t2;
            // NOR keeps the OR value in t1 for the final inversion pass
            if (r_op == OP_OR) w_last = 1'b1;
            else               w_wr_t1 = 1'b1;
          end
          default: begin
            w_x    = r_t1;
            w_y    = r_t1;
            w_last = 1'b1;
          end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (r_p)
          3'd0: w_wr_t1 = 1'b1;
          3'd1: begin
            w_y     = r_t1;
            w_wr_t2 = 1'b1;
          end
          3'd2: begin
            w_x     = r_b;
            w_y     = r_t1;
            w_wr_t1 = 1'b1;
          end
          3'd3: begin
            w_x = r_t2;
            w_y = r_t1;
            if (r_op == OP_XOR) w_last = 1'b1;
            else                w_wr_t1 = 1'b1;
          end
          default: begin
            w_x    = r_t1;
            w_y    = r_t1;
            w_last = 1'b1;
          end
        endcase
      end
      default: w_last = 1'b1; // illegal opcode: single dummy pass
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_p      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_t1     <= '0;
      r_t2     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_p     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_p <= r_p + 3'd1;
          if (w_wr_t1) r_t1 <= w_z;
          if (w_wr_t2) r_t2 <= w_z;
          if (w_last) begin
            r_result <= w_illegal ? '0 : w_z;
            r_err    <= w_illegal;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_nand_logic_sequencer.sv
module tb_nand_logic_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] last_exp = '0;

  always #5 clk = ~clk;

  nand_logic_sequencer_if #(.WIDTH(8)) u_if ();

  nand_logic_sequencer #(.WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  // Reference: plain bitwise meaning of each opcode.
  function automatic logic [7:0] model_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0: return ~(a & b);
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int model_n(input logic [2:0] o);
    case (o)
      3'd1: return 2;
      3'd2: return 3;
      3'd3, 3'd4: return 4;
      3'd5: return 5;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op and checks busy/done every cycle up to completion.
  // b2b=1: start is raised immediately (caller is inside a done cycle).
  // churn=1: start/op/a/b are scrambled every cycle while busy.
  task automatic run_op(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        input bit churn, input bit b2b);
    int n;
    logic [7:0] er;
    if (!b2b) @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = o;
    u_if.a     = ia;
    u_if.b     = ib;
    n  = model_n(o);
    er = model_res(o, ia, ib);
    @(posedge clk); #1;
    if (!churn) u_if.start = 1'b0;
    check("accept_busy", {31'd0, u_if.busy}, 32'd1);
    check("accept_done", {31'd0, u_if.done}, 32'd0);
    for (int i = 1; i <= n; i++) begin
      if (churn) begin
        @(negedge clk);
        u_if.start = ~u_if.start;
        u_if.op    = 3'($urandom);
        u_if.a     = 8'($urandom);
        u_if.b     = 8'($urandom);
      end
      @(posedge clk); #1;
      if (i < n) begin
        check("run_busy", {31'd0, u_if.busy}, 32'd1);
        check("run_done", {31'd0, u_if.done}, 32'd0);
      end else begin
        check("fin_busy",   {31'd0, u_if.busy}, 32'd0);
        check("fin_done",   {31'd0, u_if.done}, 32'd1);
        check("fin_result", {24'd0, u_if.result}, {24'd0, er});
        check("fin_err",    {31'd0, u_if.err}, {31'd0, (o == 3'd7)});
      end
    end
    u_if.start = 1'b0;
    last_exp   = er;
  endtask

  // One idle cycle after completion: nothing restarts, result is held.
  task automatic idle_check();
    @(posedge clk); #1;
    check("idle_busy",   {31'd0, u_if.busy}, 32'd0);
    check("idle_done",   {31'd0, u_if.done}, 32'd0);
    check("idle_result", {24'd0, u_if.result}, {24'd0, last_exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.start = 1'b0;
    u_if.op    = '0;
    u_if.a     = '0;
    u_if.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, u_if.busy}, 32'd0);
    check("rst_done",   {31'd0, u_if.done}, 32'd0);
    check("rst_err",    {31'd0, u_if.err}, 32'd0);
    check("rst_result", {24'd0, u_if.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: each op on 0xF0 / 0xCC
    for (int o = 0; o < 7; o++) begin
      run_op(3'(o), 8'hF0, 8'hCC, 1'b0, 1'b0);
      idle_check();
    end

    // Illegal op, then an AND that clears err
    run_op(3'd7, 8'h5A, 8'hA5, 1'b0, 1'b0);
    idle_check();
    check("err_held", {31'd0, u_if.err}, 32'd1);
    run_op(3'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    idle_check();

    // Churn while busy
    run_op(3'd4, 8'hAA, 8'h55, 1'b1, 1'b0);
    idle_check();
    idle_check();

    // Back-to-back: OR started in the AND done cycle
    run_op(3'd1, 8'h0F, 8'hFF, 1'b0, 1'b0);
    run_op(3'd2, 8'h0F, 8'hF0, 1'b0, 1'b1);
    idle_check();

    // Reset during pass 2 of XNOR
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = 3'd5;
    u_if.a     = 8'hF0;
    u_if.b     = 8'hCC;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    check("xrst_busy0", {31'd0, u_if.busy}, 32'd1);
    @(posedge clk); #1;
    check("xrst_busy1", {31'd0, u_if.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("xrst_busy",   {31'd0, u_if.busy}, 32'd0);
    check("xrst_done",   {31'd0, u_if.done}, 32'd0);
    check("xrst_result", {24'd0, u_if.result}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("xrst_nodone", {31'd0, u_if.done}, 32'd0);
    end
    run_op(3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    idle_check();

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [2:0] ro;
      logic [7:0] ra, rb;
      bit ch, bb;
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      ch = 1'($urandom);
      bb = (k > 0) && ($urandom_range(0, 3) == 0);
      run_op(ro, ra, rb, ch, bb);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
